// File: rtl/fetch_redirect_pkg.sv
// Shared definitions for the fetch/redirect slice: state encodings,
// the sequential PC step and the instruction width.
package fetch_redirect_pkg;

  // Instruction and PC width used across the fetch path
  localparam int INSTR_W = 32;

  // Byte distance between consecutive sequential fetches
  localparam int PC_INCR = 4;

  // Fetch control states
  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    HALT  = 2'd3
  } fetchState_t;

  // A redirect target is usable only if it lands on a word boundary
  function automatic logic isWordAligned(input logic [1:0] lowBits);
    return (lowBits == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_redirect_fifo.sv
// Small synchronous FIFO holding fetched instructions until decode takes
// them. Synchronous clear empties it in one edge; count/full/empty let the
// fetch unit budget its outstanding requests.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic [WIDTH-1:0] headData,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rdPtr;
  logic [AW-1:0]    wrPtr;
  logic             doPush;
  logic             doPop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign headData = mem[rdPtr];

  // A pop from an empty FIFO is ignored; a push into a full FIFO is only
  // accepted when a pop frees a slot on the same edge.
  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);

  // Storage array carries no reset; only slots behind a valid count are read
  always_ff @(posedge clk) begin
    if (doPush && !clear) begin
      mem[wrPtr] <= pushData;
    end
  end

  // Pointer and occupancy bookkeeping, clear wins over push/pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else if (clear) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) begin
        wrPtr <= wrPtr + AW'(1);
      end
      if (doPop) begin
        rdPtr <= rdPtr + AW'(1);
      end
      case ({doPush, doPop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // The fetch credit scheme must never let a response arrive at a full FIFO
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(push && full && !pop && !clear));
    end
  end

endmodule

// File: rtl/fetch_redirect.sv
// Fetch unit: owns the PC, issues instruction-memory requests under a
// credit limit, buffers in-order responses for decode, and handles taken
// branches from execute by redirecting, flushing for one cycle and
// discarding responses that belong to the abandoned path.
module fetch_redirect
  import fetch_redirect_pkg::*;
#(
  parameter int         N          = INSTR_W,
  parameter logic [N-1:0] RESET_PC = '0,
  parameter int         FIFO_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         branchValid,
  input  logic         branch,
  input  logic [N-1:0] branchTarget,
  input  logic         stall,
  output logic         imemReqValid,
  input  logic         imemReqReady,
  output logic [N-1:0] imemReqAddr,
  input  logic         imemRespValid,
  input  logic [N-1:0] imemRespData,
  output logic         instrValid,
  output logic [N-1:0] instr,
  output logic [N-1:0] instrPc,
  output logic         flush,
  output logic         misalign
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetchState_t  state;
  logic [N-1:0] pc;
  logic [N-1:0] deliverPc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] dropCnt;

  logic [CW-1:0] fifoCount;
  logic          fifoFull;
  logic          fifoEmpty;
  logic [N-1:0]  fifoHead;
  logic          fifoPush;
  logic          fifoPop;
  logic          fifoClear;

  logic          takenAny;
  logic          takenRedirect;
  logic          takenMisalign;
  logic          respFire;
  logic          reqFire;
  logic          dropResp;
  logic [CW:0]   slotsInUse;
  logic          haveCredit;

  // Branch decisions only matter while fetching normally
  assign takenAny      = (state == RUN) && branchValid && branch;
  assign takenRedirect = takenAny && isWordAligned(branchTarget[1:0]);
  assign takenMisalign = takenAny && !isWordAligned(branchTarget[1:0]);

  // Requests in flight plus buffered entries may never exceed the FIFO size,
  // which is what keeps the non-backpressuring memory from overflowing it
  assign slotsInUse   = {1'b0, outstanding} + {1'b0, fifoCount};
  assign haveCredit   = slotsInUse < (CW+1)'(FIFO_DEPTH);
  assign imemReqValid = (state == RUN) && haveCredit && !takenAny;
  assign imemReqAddr  = pc;
  assign reqFire      = imemReqValid && imemReqReady;

  // Responses are dropped while stale ones are still owed, on the redirect
  // edge itself, and forever once halted
  assign respFire  = imemRespValid;
  assign dropResp  = (dropCnt != '0) || takenAny || (state == HALT);
  assign fifoPush  = respFire && !dropResp;
  assign fifoClear = takenAny;

  // Decode sees the FIFO head except during the flush bubble; a redirect
  // overrides any pop that decode would otherwise have taken
  assign instrValid = !fifoEmpty && (state != FLUSH);
  assign instr      = fifoHead;
  assign instrPc    = deliverPc;
  assign fifoPop    = instrValid && !stall && !takenAny;

  fetch_fifo #(
    .WIDTH (N),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (fifoClear),
    .push     (fifoPush),
    .pushData (imemRespData),
    .pop      (fifoPop),
    .headData (fifoHead),
    .count    (fifoCount),
    .full     (fifoFull),
    .empty    (fifoEmpty)
  );

  // Control state machine with registered flush pulse and sticky misalign
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= BOOT;
      flush    <= 1'b0;
      misalign <= 1'b0;
    end else begin
      flush <= 1'b0;
      case (state)
        BOOT: begin
          state <= RUN;
        end
        RUN: begin
          if (takenMisalign) begin
            state    <= HALT;
            misalign <= 1'b1;
          end else if (takenRedirect) begin
            state <= FLUSH;
            flush <= 1'b1;
          end
        end
        FLUSH: begin
          state <= RUN;
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state <= BOOT;
        end
      endcase
    end
  end

  // Fetch and delivery PCs: redirect wins, otherwise step past each fire/pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= RESET_PC;
      deliverPc <= RESET_PC;
    end else if (takenRedirect) begin
      pc        <= branchTarget;
      deliverPc <= branchTarget;
    end else begin
      if (reqFire) begin
        pc <= pc + N'(PC_INCR);
      end
      if (fifoPop) begin
        deliverPc <= deliverPc + N'(PC_INCR);
      end
    end
  end

  // In-flight request count and the number of stale responses still owed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
      dropCnt     <= '0;
    end else begin
      outstanding <= outstanding + CW'(reqFire) - CW'(respFire);
      if (takenRedirect) begin
        dropCnt <= outstanding - CW'(respFire);
      end else if (respFire && (dropCnt != '0)) begin
        dropCnt <= dropCnt - CW'(1);
      end
    end
  end

  // A full buffer means every credit is used, so nothing can be in flight
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!fifoFull || (outstanding == '0));
    end
  end

endmodule
